// File: rtl/riscv_shared_sram_arbiter_if.sv
// Bundles the imem/dmem request-response buses and the SRAM port of the shared-SRAM arbiter.
// Latency: none; wires only.
// Backpressure: the resp wait signals hold each requester until its access completes.
//
// Signals:
//   imem_access_req__*  / imem_access_resp__*  instruction-fetch request and response
//   dmem_access_req__*  / dmem_access_resp__*  data-access request and response
//   sram_*                                     single-port synchronous SRAM port
// Modports:
//   slave  - the arbiter: consumes requests and SRAM read data, drives responses and the SRAM port
//   master - the environment (core plus SRAM): the mirror image of slave
interface riscv_shared_sram_arbiter_if #(
    parameter int ADDR_W = 14
);
    logic [31:0]       imem_access_req__address;
    logic              imem_access_req__read_enable;
    logic              imem_access_resp__wait;
    logic [31:0]       imem_access_resp__read_data;

    logic [31:0]       dmem_access_req__address;
    logic [3:0]        dmem_access_req__byte_enable;
    logic              dmem_access_req__write_enable;
    logic              dmem_access_req__read_enable;
    logic [31:0]       dmem_access_req__write_data;
    logic              dmem_access_resp__wait;
    logic [31:0]       dmem_access_resp__read_data;

    logic              sram_select;
    logic              sram_read_not_write;
    logic [ADDR_W-1:0] sram_address;
    logic [3:0]        sram_byte_enable;
    logic [31:0]       sram_write_data;
    logic [31:0]       sram_read_data;

    modport slave (
        input  imem_access_req__address,
        input  imem_access_req__read_enable,
        output imem_access_resp__wait,
        output imem_access_resp__read_data,
        input  dmem_access_req__address,
        input  dmem_access_req__byte_enable,
        input  dmem_access_req__write_enable,
        input  dmem_access_req__read_enable,
        input  dmem_access_req__write_data,
        output dmem_access_resp__wait,
        output dmem_access_resp__read_data,
        output sram_select,
        output sram_read_not_write,
        output sram_address,
        output sram_byte_enable,
        output sram_write_data,
        input  sram_read_data
    );

    modport master (
        output imem_access_req__address,
        output imem_access_req__read_enable,
        input  imem_access_resp__wait,
        input  imem_access_resp__read_data,
        output dmem_access_req__address,
        output dmem_access_req__byte_enable,
        output dmem_access_req__write_enable,
        output dmem_access_req__read_enable,
        output dmem_access_req__write_data,
        input  dmem_access_resp__wait,
        input  dmem_access_resp__read_data,
        input  sram_select,
        input  sram_read_not_write,
        input  sram_address,
        input  sram_byte_enable,
        input  sram_write_data,
        output sram_read_data
    );
endinterface

// File: rtl/riscv_shared_sram_arbiter.sv
// Shares one single-port synchronous SRAM between the imem (fetch) and dmem (data) ports of a RISC-V core.
// Latency: aligned access 2 cycles, halfword-aligned fetch 3 cycles; accesses never overlap.
// Backpressure: combinational wait per port holds the requester; dmem wins ties unless imem has been starved.
//
// Ports:
//   clk    - single clock, rising edge
//   reset  - synchronous, active-high
//   bus    - riscv_shared_sram_arbiter_if.slave: imem/dmem request-response and SRAM port
// Parameters:
//   ADDR_W       - SRAM word-address width (word address = byte address[ADDR_W+1:2])
//   STARVE_LIMIT - consecutive dmem grants allowed while imem waits (1..15)
// Build option:
//   SRAM_ARB_UNALIGNED_FETCH_EN - when defined, fetches with address bit 1 set read two
//   consecutive words and return the straddling 32 bits; otherwise bit 1 is ignored.
module riscv_shared_sram_arbiter #(
    parameter int ADDR_W       = 14,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    riscv_shared_sram_arbiter_if.slave    bus
);

`ifdef SRAM_ARB_UNALIGNED_FETCH_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        D_RESP = 2'd1,
        I_RESP = 2'd2,
        I_HI   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        D_RESP = 2'd1,
        I_RESP = 2'd2
    } state_t;
`endif

    localparam logic [3:0]        LIMIT    = STARVE_LIMIT[3:0];
    localparam logic [ADDR_W-1:0] WORD_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [3:0]        starve_q, starve_d;
    // Word address of the fetch in flight; kept so the second read of a
    // halfword fetch does not depend on the requester holding its address.
    logic [ADDR_W-1:0] waddr_q, waddr_d;
`ifdef SRAM_ARB_UNALIGNED_FETCH_EN
    logic [15:0]       lo_q, lo_d;
    logic              hw_q, hw_d;
`endif

    logic              imem_pend;
    logic              dmem_pend;
    logic [ADDR_W-1:0] i_word;
    logic [ADDR_W-1:0] d_word;

    logic              sel;
    logic              rnw;
    logic [ADDR_W-1:0] sram_addr;
    logic [3:0]        sram_be;
    logic [31:0]       sram_wdat;
    logic              i_wait;
    logic              d_wait;
    logic [31:0]       i_rdat;
    logic [31:0]       d_rdat;

    assign imem_pend = bus.imem_access_req__read_enable;
    assign dmem_pend = bus.dmem_access_req__write_enable | bus.dmem_access_req__read_enable;
    assign i_word    = bus.imem_access_req__address[ADDR_W+1:2];
    assign d_word    = bus.dmem_access_req__address[ADDR_W+1:2];

    // Address bits outside the SRAM word range are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.imem_access_req__address[31:ADDR_W+2],
                                bus.imem_access_req__address[1:0],
                                bus.dmem_access_req__address[31:ADDR_W+2],
                                bus.dmem_access_req__address[1:0]};

    always_comb begin
        state_d   = state_q;
        starve_d  = starve_q;
        waddr_d   = waddr_q;
`ifdef SRAM_ARB_UNALIGNED_FETCH_EN
        lo_d      = lo_q;
        hw_d      = hw_q;
`endif
        sel       = 1'b0;
        rnw       = 1'b1;
        sram_addr = '0;
        sram_be   = 4'hf;
        sram_wdat = '0;
        i_wait    = imem_pend;
        d_wait    = dmem_pend;
        i_rdat    = '0;
        d_rdat    = '0;

        case (state_q)
            IDLE: begin
                if (dmem_pend && ((starve_q < LIMIT) || !imem_pend)) begin
                    // Write takes precedence when both enables are set.
                    sel       = 1'b1;
                    rnw       = ~bus.dmem_access_req__write_enable;
                    sram_addr = d_word;
                    sram_be   = bus.dmem_access_req__write_enable ?
                                bus.dmem_access_req__byte_enable : 4'hf;
                    sram_wdat = bus.dmem_access_req__write_data;
                    starve_d  = imem_pend ? (starve_q + 4'd1) : 4'd0;
                    state_d   = D_RESP;
                end else if (imem_pend) begin
                    sel       = 1'b1;
                    sram_addr = i_word;
                    waddr_d   = i_word;
                    starve_d  = 4'd0;
`ifdef SRAM_ARB_UNALIGNED_FETCH_EN
                    hw_d      = bus.imem_access_req__address[1];
                    state_d   = bus.imem_access_req__address[1] ? I_HI : I_RESP;
`else
                    state_d   = I_RESP;
`endif
                end
            end

            D_RESP: begin
                d_wait  = 1'b0;
                d_rdat  = bus.sram_read_data;
                state_d = IDLE;
            end

`ifdef SRAM_ARB_UNALIGNED_FETCH_EN
            I_HI: begin
                // Upper half of the first word becomes the low half of the result;
                // the next word address wraps naturally at the top of the SRAM.
                lo_d      = bus.sram_read_data[31:16];
                sel       = 1'b1;
                sram_addr = waddr_q + WORD_ONE;
                state_d   = I_RESP;
            end
`endif

            I_RESP: begin
                i_wait  = 1'b0;
`ifdef SRAM_ARB_UNALIGNED_FETCH_EN
                i_rdat  = hw_q ? {bus.sram_read_data[15:0], lo_q} : bus.sram_read_data;
`else
                i_rdat  = bus.sram_read_data;
`endif
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // During reset nothing is issued and any in-flight response is dropped.
        if (reset) begin
            sel    = 1'b0;
            i_wait = imem_pend;
            d_wait = dmem_pend;
            i_rdat = '0;
            d_rdat = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            starve_q <= '0;
            waddr_q  <= '0;
`ifdef SRAM_ARB_UNALIGNED_FETCH_EN
            lo_q     <= '0;
            hw_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            waddr_q  <= waddr_d;
`ifdef SRAM_ARB_UNALIGNED_FETCH_EN
            lo_q     <= lo_d;
            hw_q     <= hw_d;
`endif
        end
    end

    assign bus.sram_select                 = sel;
    assign bus.sram_read_not_write         = rnw;
    assign bus.sram_address                = sram_addr;
    assign bus.sram_byte_enable            = sram_be;
    assign bus.sram_write_data             = sram_wdat;
    assign bus.imem_access_resp__wait      = i_wait;
    assign bus.imem_access_resp__read_data = i_rdat;
    assign bus.dmem_access_resp__wait      = d_wait;
    assign bus.dmem_access_resp__read_data = d_rdat;

endmodule

// File: doc/riscv_shared_sram_arbiter.md
Name: riscv_shared_sram_arbiter

Overview:
- Shares one single-port synchronous SRAM between the instruction-fetch and data-access ports of a minimal RISC-V core.
- Replaces the clock-divider and dual-SRAM arrangement with a wait-based handshake, so the core runs on the undivided clock.
- Sequences the two-read access needed for halfword-aligned (compressed-ISA) 32-bit fetches.
- Arbitrates dmem vs imem with a starvation guard.

Parameters:
- ADDR_W, 14: SRAM word-address width; the word address is req address[ADDR_W+1:2], and upper bits are ignored.
- STARVE_LIMIT, 4: maximum consecutive dmem grants while an imem read is pending before imem is forced through; range 1-15.

Ports:
- clk  in  1  single clock; everything on the rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_access_req__address  in  32  fetch byte address; bit 0 ignored.
- imem_access_req__read_enable  in  1  fetch request.
- imem_access_resp__wait  out  1  fetch not yet complete.
- imem_access_resp__read_data  out  32  fetch data, valid in the cycle where read_enable=1 and wait=0.
- dmem_access_req__address  in  32  data word address; bits [1:0] ignored.
- dmem_access_req__byte_enable  in  4  write byte lanes.
- dmem_access_req__write_enable  in  1  write request.
- dmem_access_req__read_enable  in  1  read request.
- dmem_access_req__write_data  in  32  write data.
- dmem_access_resp__wait  out  1  data access not yet complete.
- dmem_access_resp__read_data  out  32  read data, valid in the cycle where wait=0.
- sram_select  out  1  SRAM access this cycle.
- sram_read_not_write  out  1  1 = read, 0 = write.
- sram_address  out  ADDR_W  SRAM word address.
- sram_byte_enable  out  4  write lanes; 4'hf on reads.
- sram_write_data  out  32  write data.
- sram_read_data  in  32  SRAM output, valid the cycle after a read select.

Behaviour:
- Requester rules:
  - A request is held stable from assertion until the cycle where its wait=0; that cycle completes it.
  - dmem write_enable=1 takes precedence over read_enable. A write with read_enable also set writes, and its read_data is undefined.
- State machine (registered): IDLE, D_RESP, I_RESP, I_HI.
  - IDLE:
    - dmem request pending and (starve_cnt<STARVE_LIMIT or no imem request): issue the dmem access; next state D_RESP. starve_cnt increments if imem is pending, else clears.
    - Else if an imem read is pending: issue a read of word addr[ADDR_W+1:2]; starve_cnt clears. Next state is I_HI if addr[1]=1, else I_RESP.
    - Else: sram_select=0.
  - D_RESP:
    - dmem wait=0; read_data=sram_read_data. A write was performed at issue.
    - No SRAM access this cycle; next state IDLE.
  - I_HI:
    - Capture sram_read_data[31:16] into lo_reg.
    - Issue a read of word+1; word ADDR_W-max+1 wraps to 0.
    - Next state I_RESP.
  - I_RESP:
    - imem wait=0.
    - read_data = sram_read_data for an aligned fetch, or {sram_read_data[15:0], lo_reg} for a halfword-aligned one.
    - Next state IDLE.
- Throughput and latency:
  - Aligned access: 2 cycles. Halfword-aligned fetch: 3 cycles. No overlap between accesses.
- Wait outputs (combinational from state and request):
  - wait = read_enable|write_enable, except in that port's response state.
  - wait is 0 when the port has no request.
- Reset values:
  - state IDLE; starve_cnt 0; lo_reg 0.
  - In the reset cycle: sram_select=0, both wait = request, read_data = 0.
- Reset mid-access: returns to IDLE the next cycle. The in-flight response is discarded, and any issued SRAM write stands.
- Simultaneous requests in IDLE: dmem wins unless starve_cnt==STARVE_LIMIT, in which case imem wins.
- A request deasserted during wait (protocol violation): the FSM completes its sequence and the response is dropped.
- read_data is 0 outside the port's response state.

Optional Feature:
- Macro: SRAM_ARB_UNALIGNED_FETCH_EN.
- Defined: halfword-aligned fetch via I_HI as above.
- Undefined:
  - I_HI state and lo_reg are absent.
  - imem addr[1] is ignored; the fetch is treated as aligned, returning the full word at addr[ADDR_W+1:2] in 2 cycles.

Test Plan:
- Aligned fetch: SRAM word 0x10 = 0x12345678; imem read addr 0x40 -> wait high 1 cycle, then read_data=0x12345678 with wait=0 in cycle 2.
- Halfword-aligned fetch: word 0x10 = 0xAAAA1111, word 0x11 = 0xBBBB2222; imem read addr 0x42 -> two selects (addresses 0x10, 0x11), read_data=0x2222AAAA in cycle 3. With the macro undefined -> 0xAAAA1111 in cycle 2.
- Data write then read:
  - Write addr 0x80, byte_enable 4'b0011, data 0xDEADBEEF over a word preset to 0 -> completes cycle 2.
  - Read of the same address -> 0x0000BEEF.
- Starvation: dmem and imem both requesting continuously, STARVE_LIMIT=4 -> exactly 4 dmem grants, then 1 imem grant, repeating.
- Wraparound: imem addr 0xFFFE (ADDR_W=14) -> second read at sram_address 0; data = {word0[15:0], word0x3FFF[31:16]}.
- Reset mid-fetch: assert reset in the I_HI cycle -> sram_select=0 in that cycle; after release with the request held, the fetch restarts from IDLE and completes 3 cycles later.
